// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared encodings for the writeback stage
// Purpose: result-source select codes, load funct3 codes and FSM state encoding.
package wb_stage_pkg;

  localparam logic [1:0] WBSEL_ALU    = 2'b00;
  localparam logic [1:0] WBSEL_PCADD4 = 2'b01;
  localparam logic [1:0] WBSEL_MEM    = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - load data alignment and sign/zero extension
// Purpose: picks the byte/half addressed by off out of the raw word and extends it.
// Ports:
//   funct3  in   3     load type (LB/LH/LW/LBU/LHU)
//   off     in   2     byte offset within the word
//   data    in   XLEN  raw aligned word from data memory
//   result  out  XLEN  extended load value
module load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // off[0] is ignored for halves; misaligned halves never reach this stage.
  assign byte_v = data[{off, 3'b000} +: 8];
  assign half_v = data[{off[1], 4'b0000} +: 16];

  always_comb begin
    result = data;
    case (funct3)
      LD_LB:   result = {{(XLEN-8){byte_v[7]}}, byte_v};
      LD_LH:   result = {{(XLEN-16){half_v[15]}}, half_v};
      LD_LBU:  result = {{(XLEN-8){1'b0}}, byte_v};
      LD_LHU:  result = {{(XLEN-16){1'b0}}, half_v};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered writeback stage with load wait and timeout
// Purpose: selects ALU / PC+4 / load data, waits for the load response and
//   drives the register-file write port (also used as the forwarding copy).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid_i / in_ready_o       MEM-stage handshake
//   wbsel_i, alu_i, pc_i          result source select and candidates
//   rd_i, rd_we_i                 destination register and write enable
//   ld_funct3_i, ld_off_i         load type and byte offset
//   dresp_valid_i, dresp_data_i   data memory response
//   rf_we_o, rf_waddr_o, rf_wdata_o  register-file write port
//   busy_o                        load pending (stall)
//   bus_err_o                     one-cycle pulse on load timeout
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      wbsel_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [4:0]      rd_i,
  input  logic            rd_we_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic            dresp_valid_i,
  input  logic [XLEN-1:0] dresp_data_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            busy_o,
  output logic            bus_err_o
);

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       ld_rd_q;
  logic             ld_we_q;
  logic [2:0]       ld_f3_q;
  logic [1:0]       ld_off_q;
  logic             capture;
  logic             rf_we_d, bus_err_d;
  logic [4:0]       rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_d;
  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  pc_plus4;
  logic             timeout_hit;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3 (ld_f3_q),
    .off    (ld_off_q),
    .data   (dresp_data_i),
    .result (ld_data)
  );

  assign pc_plus4   = pc_i + XLEN'(4);
  assign in_ready_o = (state_q == WB_IDLE);
  assign busy_o     = (state_q == WB_WAIT_LD);

  // The cycle whose increment would bring the count to LD_TIMEOUT is the last one waited.
  assign timeout_hit = (LD_TIMEOUT != 0) && (cnt_q == CNT_W'(LD_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    rf_we_d    = 1'b0;
    bus_err_d  = 1'b0;
    rf_waddr_d = rf_waddr_o;
    rf_wdata_d = rf_wdata_o;
    case (state_q)
      WB_IDLE: begin
        if (in_valid_i) begin
          if (wbsel_i == WBSEL_MEM) begin
            capture = 1'b1;
            cnt_d   = '0;
            state_d = WB_WAIT_LD;
          end else begin
            rf_we_d = rd_we_i && (rd_i != 5'd0);
            if (rf_we_d) begin
              rf_waddr_d = rd_i;
              rf_wdata_d = (wbsel_i == WBSEL_PCADD4) ? pc_plus4 : alu_i;
            end
          end
        end
      end
      WB_WAIT_LD: begin
        // A response in the timeout cycle takes priority over the abort.
        if (dresp_valid_i) begin
          state_d = WB_IDLE;
          rf_we_d = ld_we_q && (ld_rd_q != 5'd0);
          if (rf_we_d) begin
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = ld_data;
          end
        end else if (timeout_hit) begin
          state_d   = WB_IDLE;
          bus_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      cnt_q      <= '0;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_we_o    <= rf_we_d;
      rf_waddr_o <= rf_waddr_d;
      rf_wdata_o <= rf_wdata_d;
      bus_err_o  <= bus_err_d;
      if (capture) begin
        ld_rd_q  <= rd_i;
        ld_we_q  <= rd_we_i;
        ld_f3_q  <= ld_funct3_i;
        ld_off_q <= ld_off_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - testbench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  wbsel_i;
  logic [31:0] alu_i;
  logic [31:0] pc_i;
  logic [4:0]  rd_i;
  logic        rd_we_i;
  logic [2:0]  ld_funct3_i;
  logic [1:0]  ld_off_i;
  logic        dresp_valid_i;
  logic [31:0] dresp_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        busy_o;
  logic        bus_err_o;

  typedef struct packed {
    logic        err;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  wb_stage #(.XLEN(32), .LD_TIMEOUT(4), .CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .wbsel_i       (wbsel_i),
    .alu_i         (alu_i),
    .pc_i          (pc_i),
    .rd_i          (rd_i),
    .rd_we_i       (rd_we_i),
    .ld_funct3_i   (ld_funct3_i),
    .ld_off_i      (ld_off_i),
    .dresp_valid_i (dresp_valid_i),
    .dresp_data_i  (dresp_data_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .busy_o        (busy_o),
    .bus_err_o     (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (rf_we_o || bus_err_o)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: we=%b err=%b addr=%0d data=%h, nothing expected",
                 rf_we_o, bus_err_o, rf_waddr_o, rf_wdata_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.err) begin
          if (!bus_err_o || rf_we_o) begin
            errors++;
            $display("FAIL bus_err: got err=%b we=%b expected err=1 we=0", bus_err_o, rf_we_o);
          end
        end else if (!rf_we_o || bus_err_o || rf_waddr_o !== e.addr || rf_wdata_o !== e.data) begin
          errors++;
          $display("FAIL rf_write: got we=%b err=%b addr=%0d data=%h expected addr=%0d data=%h",
                   rf_we_o, bus_err_o, rf_waddr_o, rf_wdata_o, e.addr, e.data);
        end
      end
    end
  end

  task automatic send(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                      input logic [4:0] rd, input logic we, input logic [2:0] f3,
                      input logic [1:0] off);
    int n;
    in_valid_i  = 1'b1;
    wbsel_i     = sel;
    alu_i       = alu;
    pc_i        = pc;
    rd_i        = rd;
    rd_we_i     = we;
    ld_funct3_i = f3;
    ld_off_i    = off;
    n = 0;
    while (!in_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) chk("accept_timeout", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;
    in_valid_i    = 1'b0;
    dresp_valid_i = 1'b0;
  endtask

  // Called just after the acceptance edge; gap=1 answers in the first WAIT_LD cycle.
  task automatic resp(input int gap, input logic [31:0] d);
    repeat (gap - 1) @(posedge clk);
    #1;
    dresp_valid_i = 1'b1;
    dresp_data_i  = d;
    @(posedge clk); #1;
    dresp_valid_i = 1'b0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                      input logic [31:0] d, input logic [31:0] expv, input logic do_exp);
    if (do_exp) exp_q.push_back('{err: 1'b0, addr: rd, data: expv});
    send(2'b10, 32'h0, 32'h0, rd, 1'b1, f3, off);
    resp(1, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; wbsel_i = 2'b00; alu_i = '0; pc_i = '0; rd_i = '0;
    rd_we_i = 1'b0; ld_funct3_i = '0; ld_off_i = '0; dresp_valid_i = 1'b0; dresp_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_we", 32'(rf_we_o), 32'd0);
    chk("reset_waddr", 32'(rf_waddr_o), 32'd0);
    chk("reset_wdata", rf_wdata_o, 32'd0);
    chk("reset_err", 32'(bus_err_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;

    exp_q.push_back('{err: 1'b0, addr: 5'd5, data: 32'hDEADBEEF});
    send(2'b00, 32'hDEADBEEF, 32'h0, 5'd5, 1'b1, 3'b0, 2'b0);
    exp_q.push_back('{err: 1'b0, addr: 5'd1, data: 32'h00000000});
    send(2'b01, 32'h0, 32'hFFFFFFFC, 5'd1, 1'b1, 3'b0, 2'b0);
    exp_q.push_back('{err: 1'b0, addr: 5'd7, data: 32'h12345678});
    send(2'b11, 32'h12345678, 32'h0, 5'd7, 1'b1, 3'b0, 2'b0);
    send(2'b00, 32'h55555555, 32'h0, 5'd3, 1'b0, 3'b0, 2'b0);
    send(2'b00, 32'h66666666, 32'h0, 5'd0, 1'b1, 3'b0, 2'b0);
    @(negedge clk);
    chk("hold_waddr", 32'(rf_waddr_o), 32'd7);
    chk("hold_wdata", rf_wdata_o, 32'h12345678);

    // LB with a stray response in the acceptance cycle, real response two cycles later.
    exp_q.push_back('{err: 1'b0, addr: 5'd9, data: 32'hFFFFFF80});
    dresp_valid_i = 1'b1; dresp_data_i = 32'h000000FF;
    send(2'b10, 32'h0, 32'h0, 5'd9, 1'b1, 3'b000, 2'd3);
    @(negedge clk);
    chk("lb_busy", 32'(busy_o), 32'd1);
    chk("lb_ready", 32'(in_ready_o), 32'd0);
    resp(2, 32'h80112233);
    @(negedge clk);
    chk("lb_busy_after", 32'(busy_o), 32'd0);
    chk("lb_ready_after", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;

    load(3'b101, 2'd2, 5'd10, 32'h80017FFF, 32'h00008001, 1'b1);
    load(3'b101, 2'd2, 5'd0,  32'h80017FFF, 32'h00008001, 1'b0);
    load(3'b001, 2'd0, 5'd11, 32'h00008000, 32'hFFFF8000, 1'b1);
    load(3'b010, 2'd1, 5'd12, 32'hA5A51234, 32'hA5A51234, 1'b1);
    load(3'b100, 2'd1, 5'd13, 32'h0000F100, 32'h000000F1, 1'b1);
    load(3'b000, 2'd2, 5'd14, 32'h007F0000, 32'h0000007F, 1'b1);

    // Timeout with no response.
    exp_q.push_back('{err: 1'b1, addr: 5'd0, data: 32'h0});
    send(2'b10, 32'h0, 32'h0, 5'd15, 1'b1, 3'b010, 2'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("timeout_ready", 32'(in_ready_o), 32'd1);
    chk("timeout_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    dresp_valid_i = 1'b1; dresp_data_i = 32'h99999999;
    @(posedge clk); #1;
    dresp_valid_i = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Response in the exact timeout cycle wins.
    exp_q.push_back('{err: 1'b0, addr: 5'd16, data: 32'hCAFEF00D});
    send(2'b10, 32'h0, 32'h0, 5'd16, 1'b1, 3'b010, 2'd0);
    resp(4, 32'hCAFEF00D);
    repeat (3) @(posedge clk); #1;

    // Reset while a load is pending.
    send(2'b10, 32'h0, 32'h0, 5'd17, 1'b1, 3'b010, 2'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; dresp_valid_i = 1'b1; dresp_data_i = 32'h11111111;
    @(posedge clk); #1;
    dresp_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", 32'(rf_we_o), 32'd0);
    chk("rst_mid_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_mid_wdata", rf_wdata_o, 32'd0);
    chk("rst_mid_ready", 32'(in_ready_o), 32'd1);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
